flash_bus_ctrl: RTL and testbench



---
 rtl/cdb_flash_pkg.sv | 21 ++
 rtl/flash_bus_ctrl_if.sv | 33 +++
 rtl/flash_ready_sync.sv | 12 +
 rtl/flash_bus_ctrl.sv | 109 ++++++++++
 tb/tb_flash_bus_ctrl.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/cdb_flash_pkg.sv
// cdb_flash_pkg: FSM state encoding and default 48 MHz timing for the parallel-NOR flash controller
package cdb_flash_pkg;
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_STROBE = 3'd2;
  localparam logic [2:0] S_HOLD   = 3'd3;
  localparam logic [2:0] S_BLANK  = 3'd4;
  localparam logic [2:0] S_POLL   = 3'd5;
  localparam logic [2:0] S_RESP   = 3'd6;
  localparam int ADDR_W_DEF        = 26;
  localparam int DATA_W_DEF        = 16;
  localparam int SETUP_CYC_DEF     = 1;
  localparam int RD_PULSE_CYC_DEF  = 5;
  localparam int WR_PULSE_CYC_DEF  = 3;
  localparam int HOLD_CYC_DEF      = 1;
  localparam int RDY_BLANK_CYC_DEF = 4;
  localparam int TIMEOUT_CYC_DEF   = 4800000;
  function automatic int max2(int a, int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/flash_bus_ctrl_if.sv
// flash_bus_ctrl_if: request/response handshake plus flash pin bundle; slave is the controller side
interface flash_bus_ctrl_if import cdb_flash_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic              req_poll;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_timeout;
  logic [ADDR_W-1:0] flash_a;
  logic [DATA_W-1:0] flash_dq_o;
  logic              flash_dq_oe;
  logic [DATA_W-1:0] flash_dq_i;
  logic              flash_nce;
  logic              flash_noe;
  logic              flash_nwe;
  logic              flash_ready;
  modport master (
    output req_valid, req_write, req_poll, req_addr, req_wdata, flash_dq_i, flash_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_timeout, flash_a, flash_dq_o, flash_dq_oe,
           flash_nce, flash_noe, flash_nwe
  );
  modport slave (
    input  req_valid, req_write, req_poll, req_addr, req_wdata, flash_dq_i, flash_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_timeout, flash_a, flash_dq_o, flash_dq_oe,
           flash_nce, flash_noe, flash_nwe
  );
endinterface

// File: rtl/flash_ready_sync.sv
// flash_ready_sync: 2-FF synchroniser for the flash R/nB line, resets to ready
module flash_ready_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk or posedge rst)
    if (rst) {q, meta} <= 2'b11;
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/flash_bus_ctrl.sv
// flash_bus_ctrl: turns single-word read/write requests into timed nCE/nOE/nWE cycles on a parallel-NOR flash
module flash_bus_ctrl import cdb_flash_pkg::*; #(
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int DATA_W        = DATA_W_DEF,
  parameter int SETUP_CYC     = SETUP_CYC_DEF,
  parameter int RD_PULSE_CYC  = RD_PULSE_CYC_DEF,
  parameter int WR_PULSE_CYC  = WR_PULSE_CYC_DEF,
  parameter int HOLD_CYC      = HOLD_CYC_DEF,
  parameter int RDY_BLANK_CYC = RDY_BLANK_CYC_DEF,
  parameter int TIMEOUT_CYC   = TIMEOUT_CYC_DEF
) (
  input logic             clk_48mhz,
  input logic             internal_rst,
  flash_bus_ctrl_if.slave bus
);
  localparam int PH_MAX = max2(max2(max2(SETUP_CYC, RD_PULSE_CYC), max2(WR_PULSE_CYC, HOLD_CYC)), RDY_BLANK_CYC);
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CYC + 1);
  logic [2:0]      state;
  logic [PH_W-1:0] cnt;
  logic [PH_W-1:0] lim;
  logic [TO_W-1:0] wcnt;
  logic [TO_W-1:0] wcnt_nxt;
  logic            wr;
  logic            poll;
  logic            rdy_s;
  logic            last;
  flash_ready_sync u_sync (.clk(clk_48mhz), .rst(internal_rst), .d(bus.flash_ready), .q(rdy_s));
  always_comb begin
    lim = state == S_SETUP  ? PH_W'(SETUP_CYC - 1) :
          state == S_STROBE ? (wr ? PH_W'(WR_PULSE_CYC - 1) : PH_W'(RD_PULSE_CYC - 1)) :
          state == S_HOLD   ? PH_W'(HOLD_CYC - 1) : PH_W'(RDY_BLANK_CYC - 1);
    last = cnt == lim;
    wcnt_nxt = wcnt == TO_W'(TIMEOUT_CYC) ? wcnt : wcnt + 1'b1;
  end
  always_ff @(posedge clk_48mhz or posedge internal_rst) begin
    if (internal_rst) begin
      state            <= S_IDLE;
      cnt              <= '0;
      wcnt             <= '0;
      wr               <= 1'b0;
      poll             <= 1'b0;
      bus.req_ready    <= 1'b1;
      bus.rsp_valid    <= 1'b0;
      bus.rsp_rdata    <= '0;
      bus.rsp_timeout  <= 1'b0;
      bus.flash_a      <= '0;
      bus.flash_dq_o   <= '0;
      bus.flash_dq_oe  <= 1'b0;
      bus.flash_nce    <= 1'b1;
      bus.flash_noe    <= 1'b1;
      bus.flash_nwe    <= 1'b1;
    end else begin
      cnt           <= (state == S_IDLE || state == S_POLL || state == S_RESP || last) ? '0 : cnt + 1'b1;
      bus.rsp_valid <= 1'b0;
      case (state)
        S_IDLE: if (bus.req_valid && bus.req_ready) begin
          state           <= S_SETUP;
          bus.req_ready   <= 1'b0;
          wr              <= bus.req_write;
          poll            <= bus.req_write & bus.req_poll;
          bus.rsp_timeout <= 1'b0;
          bus.flash_a     <= bus.req_addr[ADDR_W-1:0];
          bus.flash_nce   <= 1'b0;
          if (bus.req_write) begin
            bus.flash_dq_o  <= bus.req_wdata[DATA_W-1:0];
            bus.flash_dq_oe <= 1'b1;
          end
        end
        S_SETUP: if (last) begin
          state         <= S_STROBE;
          bus.flash_noe <= wr;
          bus.flash_nwe <= !wr;
        end
        S_STROBE: if (last) begin
          state         <= S_HOLD;
          bus.flash_noe <= 1'b1;
          bus.flash_nwe <= 1'b1;
          if (!wr) bus.rsp_rdata <= bus.flash_dq_i;
        end
        S_HOLD: if (last) begin
          state           <= poll ? S_BLANK : S_RESP;
          bus.rsp_valid   <= !poll;
          bus.flash_nce   <= 1'b1;
          bus.flash_dq_oe <= 1'b0;
          wcnt            <= TO_W'(1);
        end
        S_BLANK: begin
          wcnt <= wcnt_nxt;
          if (last) state <= S_POLL;
        end
        S_POLL: begin
          wcnt <= wcnt_nxt;
          // ready wins over a timeout that expires in the same cycle
          if (rdy_s || wcnt >= TO_W'(TIMEOUT_CYC)) begin
            state           <= S_RESP;
            bus.rsp_valid   <= 1'b1;
            bus.rsp_timeout <= !rdy_s;
          end
        end
        S_RESP: begin
          state         <= S_IDLE;
          bus.req_ready <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_flash_bus_ctrl.sv
// tb_flash_bus_ctrl: directed table, corner sequences and random traffic against a flash memory model
module tb_flash_bus_ctrl;
  localparam int S = 1, R = 5, W = 3, H = 1, B = 4, TO = 50;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_pass = 0, n_tot = 0, viol = 0;
  logic [15:0] fmem [logic [25:0]];
  logic [15:0] rmem [logic [25:0]];
  logic [15:0] last_rd = 16'h0;
  flash_bus_ctrl_if #(.ADDR_W(26), .DATA_W(16)) bus ();
  flash_bus_ctrl_if #(.ADDR_W(26), .DATA_W(16)) bto ();
  flash_bus_ctrl #(.ADDR_W(26), .DATA_W(16), .SETUP_CYC(S), .RD_PULSE_CYC(R), .WR_PULSE_CYC(W),
    .HOLD_CYC(H), .RDY_BLANK_CYC(B), .TIMEOUT_CYC(4800000)) u_dut (.clk_48mhz(clk), .internal_rst(rst), .bus(bus));
  flash_bus_ctrl #(.ADDR_W(26), .DATA_W(16), .SETUP_CYC(S), .RD_PULSE_CYC(R), .WR_PULSE_CYC(W),
    .HOLD_CYC(H), .RDY_BLANK_CYC(B), .TIMEOUT_CYC(TO)) u_to (.clk_48mhz(clk), .internal_rst(rst), .bus(bto));
  always #10 clk = ~clk;
  function automatic logic [15:0] dflt(input logic [25:0] a);
    return a[15:0] ^ 16'h5A5A;
  endfunction
  function automatic void chk(input string nm, input longint act, input longint exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endfunction
  // flash model: array written on nWE rise, read data presented from current address
  always @(negedge clk) bus.flash_dq_i = fmem.exists(bus.flash_a) ? fmem[bus.flash_a] : dflt(bus.flash_a);
  always @(posedge bus.flash_nwe) if (!rst && bus.flash_nce === 1'b0) fmem[bus.flash_a] = bus.flash_dq_o;
  always @(negedge clk) if (!rst && ((bus.flash_dq_oe && !bus.flash_noe) || (bto.flash_dq_oe && !bto.flash_noe) ||
                                     (!bus.flash_noe && !bus.flash_nwe))) viol++;
  task automatic do_req(input logic w, input logic p, input logic [25:0] a, input logic [15:0] d,
                        output int lat, output int n_noe, output int n_nwe, output int n_nce, output int n_oe,
                        output logic [15:0] rd, output logic to);
    lat = -1; n_noe = 0; n_nwe = 0; n_nce = 0; n_oe = 0; rd = 'x; to = 'x;
    for (int g = 0; g < 10 && !bus.req_ready; g++) @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = w; bus.req_poll = p; bus.req_addr = a; bus.req_wdata = d;
    for (int k = 1; k <= 300 && lat < 0; k++) begin
      @(negedge clk);
      if (k == 1) bus.req_valid = 1'b0;
      n_noe += int'(!bus.flash_noe); n_nwe += int'(!bus.flash_nwe);
      n_nce += int'(!bus.flash_nce); n_oe += int'(bus.flash_dq_oe);
      if (bus.rsp_valid) begin lat = k; rd = bus.rsp_rdata; to = bus.rsp_timeout; end
    end
  endtask
  typedef struct {
    logic w; logic p; logic [25:0] a; logic [15:0] d;
    int lat; int noe; int nwe; int nce; int oe; logic [15:0] rd;
  } vec_t;
  vec_t vt [6];
  initial begin
    int lat, n_noe, n_nwe, n_nce, n_oe, k0, rise_k, rel_k, rsp_k, hold_k;
    logic [15:0] rd, erd, d;
    logic [25:0] a;
    logic to, w, p, seen, early;
    vt[0] = '{1'b0, 1'b0, 26'h0001234, 16'h0000, 8, 5, 0, 7, 0, 16'hBEEF};
    vt[1] = '{1'b1, 1'b0, 26'h3FFFFFF, 16'hA55A, 6, 0, 3, 5, 5, 16'hBEEF};
    vt[2] = '{1'b0, 1'b0, 26'h3FFFFFF, 16'h0000, 8, 5, 0, 7, 0, 16'hA55A};
    vt[3] = '{1'b1, 1'b1, 26'h0000000, 16'h0F0F, 11, 0, 3, 5, 5, 16'hA55A};
    vt[4] = '{1'b0, 1'b0, 26'h0000000, 16'h0000, 8, 5, 0, 7, 0, 16'h0F0F};
    vt[5] = '{1'b0, 1'b0, 26'h2AAAAAA, 16'h0000, 8, 5, 0, 7, 0, 16'hF0F0};
    fmem[26'h0001234] = 16'hBEEF;
    rmem[26'h0001234] = 16'hBEEF;
    bus.req_valid = 0; bus.req_write = 0; bus.req_poll = 0; bus.req_addr = 0; bus.req_wdata = 0; bus.flash_ready = 1;
    bto.req_valid = 0; bto.req_write = 0; bto.req_poll = 0; bto.req_addr = 0; bto.req_wdata = 0;
    bto.flash_ready = 0; bto.flash_dq_i = 16'h1357;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 1);   chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);   chk("rst_rsp_timeout", bus.rsp_timeout, 0);
    chk("rst_flash_a", bus.flash_a, 0);       chk("rst_dq_o", bus.flash_dq_o, 0);
    chk("rst_dq_oe", bus.flash_dq_oe, 0);     chk("rst_nce", bus.flash_nce, 1);
    chk("rst_noe", bus.flash_noe, 1);         chk("rst_nwe", bus.flash_nwe, 1);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      do_req(vt[i].w, vt[i].p, vt[i].a, vt[i].d, lat, n_noe, n_nwe, n_nce, n_oe, rd, to);
      chk($sformatf("vec%0d_latency", i), lat, vt[i].lat);
      chk($sformatf("vec%0d_noe_cycles", i), n_noe, vt[i].noe);
      chk($sformatf("vec%0d_nwe_cycles", i), n_nwe, vt[i].nwe);
      chk($sformatf("vec%0d_nce_cycles", i), n_nce, vt[i].nce);
      chk($sformatf("vec%0d_oe_cycles", i), n_oe, vt[i].oe);
      chk($sformatf("vec%0d_rdata", i), rd, vt[i].rd);
      chk($sformatf("vec%0d_timeout", i), to, 0);
      if (vt[i].w) begin
        chk($sformatf("vec%0d_flash_mem", i), fmem.exists(vt[i].a) ? fmem[vt[i].a] : 17'h1ffff, vt[i].d);
        rmem[vt[i].a] = vt[i].d;
      end else last_rd = vt[i].rd;
    end
    // polled write: ready falls after the write and releases 100 cycles later
    @(negedge clk);
    bus.req_valid = 1; bus.req_write = 1; bus.req_poll = 1; bus.req_addr = 26'h55; bus.req_wdata = 16'h1111;
    seen = 0; rise_k = -1; rel_k = -1; rsp_k = -1; early = 0; to = 'x;
    for (int k = 1; k <= 400 && rsp_k < 0; k++) begin
      @(negedge clk);
      if (k == 1) bus.req_valid = 0;
      if (!bus.flash_nwe) seen = 1; else if (seen && rise_k < 0) rise_k = k;
      if (bus.rsp_valid) begin rsp_k = k; to = bus.rsp_timeout; early = rel_k < 0; end
      else if (rise_k > 0 && k == rise_k + 2) bus.flash_ready = 0;
      else if (rise_k > 0 && k == rise_k + 102) begin bus.flash_ready = 1; rel_k = k; end
    end
    chk("poll_early_rsp", early, 0);
    chk("poll_rsp_after_release", rsp_k - rel_k, 3);
    chk("poll_timeout", to, 0);
    rmem[26'h55] = 16'h1111;
    // timeout instance: ready held low for the whole write
    @(negedge clk);
    bto.req_valid = 1; bto.req_write = 1; bto.req_poll = 1; bto.req_addr = 26'h5; bto.req_wdata = 16'h2222;
    seen = 0; hold_k = -1; rsp_k = -1; to = 'x;
    for (int k = 1; k <= 200 && rsp_k < 0; k++) begin
      @(negedge clk);
      if (k == 1) bto.req_valid = 0;
      if (!bto.flash_nce) seen = 1; else if (seen && hold_k < 0) hold_k = k;
      if (bto.rsp_valid) begin rsp_k = k; to = bto.rsp_timeout; end
    end
    chk("timeout_delay", rsp_k - hold_k, TO);
    chk("timeout_flag", to, 1);
    bto.req_valid = 1; bto.req_write = 0; bto.req_poll = 0; bto.req_addr = 26'h9;
    @(negedge clk);
    chk("timeout_held_idle", bto.rsp_timeout, 1);
    @(negedge clk);
    bto.req_valid = 0;
    chk("timeout_clr_on_accept", bto.rsp_timeout, 0);
    rsp_k = -1;
    for (int k = 2; k <= 50 && rsp_k < 0; k++) begin
      @(negedge clk);
      if (bto.rsp_valid) begin rsp_k = k; rd = bto.rsp_rdata; to = bto.rsp_timeout; end
    end
    chk("timeout_read_latency", rsp_k, S + R + H + 1);
    chk("timeout_read_rdata", rd, 16'h1357);
    chk("timeout_read_flag", to, 0);
    // back-to-back: request held valid, write then read of the same word
    @(negedge clk);
    bus.req_valid = 1; bus.req_write = 1; bus.req_poll = 0; bus.req_addr = 26'h77; bus.req_wdata = 16'hC3C3;
    rsp_k = -1;
    for (int k = 1; k <= 50 && rsp_k < 0; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) rsp_k = k;
    end
    chk("b2b_resp_strobes_high", {bus.flash_nce, bus.flash_noe, bus.flash_nwe, bus.flash_dq_oe}, 4'b1110);
    bus.req_write = 0; bus.req_addr = 26'h77;
    @(negedge clk);
    chk("b2b_idle_ready", {bus.req_ready, bus.flash_nce}, 2'b11);
    @(negedge clk);
    chk("b2b_second_accept", {bus.req_ready, bus.flash_nce}, 2'b00);
    rsp_k = -1;
    for (int k = 2; k <= 50 && rsp_k < 0; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin rsp_k = k; rd = bus.rsp_rdata; bus.req_valid = 0; end
    end
    bus.req_valid = 0;
    chk("b2b_read_latency", rsp_k, S + R + H + 1);
    chk("b2b_read_rdata", rd, 16'hC3C3);
    rmem[26'h77] = 16'hC3C3; last_rd = 16'hC3C3;
    // reset asserted while nWE is low
    @(negedge clk);
    bus.req_valid = 1; bus.req_write = 1; bus.req_poll = 0; bus.req_addr = 26'h99; bus.req_wdata = 16'hDEAD;
    @(negedge clk); bus.req_valid = 0;
    @(negedge clk);
    chk("rst_mid_nwe_low", bus.flash_nwe, 0);
    #3 rst = 1;
    #1;
    chk("rst_mid_async", {bus.flash_nwe, bus.flash_nce, bus.flash_dq_oe}, 3'b110);
    @(negedge clk); rst = 0;
    seen = 0;
    repeat (20) begin @(negedge clk); if (bus.rsp_valid) seen = 1; end
    chk("rst_mid_no_rsp", seen, 0);
    chk("rst_mid_ready", bus.req_ready, 1);
    last_rd = 16'h0;
    // random traffic against the memory model
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(3, 0)) @(negedge clk);
      w = 1'($urandom_range(1, 0));
      p = w && $urandom_range(3, 0) == 0;
      a = 26'h100 + 26'($urandom_range(7, 0));
      d = 16'($urandom);
      erd = w ? last_rd : (rmem.exists(a) ? rmem[a] : dflt(a));
      do_req(w, p, a, d, lat, n_noe, n_nwe, n_nce, n_oe, rd, to);
      k0 = S + (w ? W : R) + H;
      chk($sformatf("rnd%0d_latency", i), lat, k0 + 1 + (p ? B + 1 : 0));
      chk($sformatf("rnd%0d_pulse", i), w ? n_nwe : n_noe, w ? W : R);
      chk($sformatf("rnd%0d_nce", i), n_nce, k0);
      chk($sformatf("rnd%0d_oe", i), n_oe, w ? k0 : 0);
      chk($sformatf("rnd%0d_rdata", i), rd, erd);
      chk($sformatf("rnd%0d_timeout", i), to, 0);
      if (w) begin
        chk($sformatf("rnd%0d_flash_mem", i), fmem.exists(a) ? fmem[a] : 17'h1ffff, d);
        rmem[a] = d;
      end else last_rd = erd;
    end
    chk("bus_turnaround_violations", viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
